mem_arbiter: RTL

- Shares one single-port instruction/data memory between the instruction fetch path (IFU) and the load/store unit (LSU).
- Accepts one transaction at a time, forwards it to the memory, and routes the response back to the requester that issued it.
- A watchdog returns an error response if the memory never answers.
- Sits between the fetch/LSU logic and the memory macro.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_timer.sv | 33 +++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the IFU/LSU memory arbiter
// Contents: owner_e (which requester owns the in-flight transaction),
//           state_e (arbiter FSM states), BMASK_ALL (full-word byte lanes).
package mem_arb_pkg;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam logic [3:0] BMASK_ALL = 4'hF;

endpackage

// File: rtl/mem_arb_timer.sv
// rtl/mem_arb_timer.sv - response watchdog counter for the memory arbiter
// Ports: clk_i, rst_ni (sync, active-low), clr (zero the count),
//        en (count one cycle), expired (high while enabled and the count is TIMEOUT_CYC-1).
// The first enabled cycle after clr sees count 0, so expired fires on the
// TIMEOUT_CYC-th enabled cycle.
module mem_arb_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int              CW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expired = en && (count_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port memory between the IFU and the LSU
// Ports: clk_i, rst_ni (sync, active-low);
//        IFU  : if_req_i, if_addr_i -> if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o
//        LSU  : lsu_req_i, lsu_addr_i, lsu_wren_i, lsu_wdata_i, lsu_bmask_i
//               -> lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o
//        MEM  : mem_req_o, mem_addr_o, mem_wren_o, mem_wdata_o, mem_bmask_o <- mem_rvalid_i, mem_rdata_i
//        busy_o : FSM not idle.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration on ties
// (default: LSU has fixed priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    output logic              if_err_o,
    input  logic              lsu_req_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic              lsu_wren_i,
    input  logic [31:0]       lsu_wdata_i,
    input  logic [3:0]        lsu_bmask_i,
    output logic              lsu_gnt_o,
    output logic              lsu_rvalid_o,
    output logic [31:0]       lsu_rdata_o,
    output logic              lsu_err_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wren_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_bmask_o,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              busy_o
);

    state_e state_q;
    owner_e owner_q;

    logic        pick_lsu;
    logic        grant_any;
    logic        timer_expired;
    logic        resp_done;
    logic        resp_err;
    logic [31:0] resp_data;

    // The memory is word addressed; byte offsets only matter through the lane mask.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[1:0], lsu_addr_i[1:0]};

`ifdef MEM_ARB_RR_EN
    owner_e last_owner_q;

    // On a tie the requester that did not own the previous transaction wins.
    assign pick_lsu = lsu_req_i && (!if_req_i || (last_owner_q == OWN_IFU));
`else
    assign pick_lsu = lsu_req_i;
`endif

    // Grants exist only in IDLE; gated by reset so every output is quiet while held in reset.
    assign grant_any = rst_ni && (state_q == S_IDLE) && (if_req_i || lsu_req_i);
    assign lsu_gnt_o = grant_any && pick_lsu;
    assign if_gnt_o  = grant_any && !pick_lsu;
    assign busy_o    = (state_q != S_IDLE);

    mem_arb_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr     (state_q == S_ISSUE),
        .en      (state_q == S_WAIT),
        .expired (timer_expired)
    );

    // A real response beats the watchdog when both land in the same cycle.
    assign resp_done = (state_q == S_WAIT) && (mem_rvalid_i || timer_expired);
    assign resp_err  = !mem_rvalid_i;
    assign resp_data = (mem_rvalid_i && !mem_wren_o) ? mem_rdata_i : 32'h0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IFU;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= OWN_IFU;
`endif
            mem_req_o    <= 1'b0;
            mem_addr_o   <= '0;
            mem_wren_o   <= 1'b0;
            mem_wdata_o  <= '0;
            mem_bmask_o  <= '0;
            if_rvalid_o  <= 1'b0;
            if_rdata_o   <= '0;
            if_err_o     <= 1'b0;
            lsu_rvalid_o <= 1'b0;
            lsu_rdata_o  <= '0;
            lsu_err_o    <= 1'b0;
        end else begin
            mem_req_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (lsu_gnt_o) begin
                        owner_q     <= OWN_LSU;
                        mem_req_o   <= 1'b1;
                        mem_addr_o  <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
                        mem_wren_o  <= lsu_wren_i;
                        mem_wdata_o <= lsu_wdata_i;
                        mem_bmask_o <= lsu_bmask_i;
                        state_q     <= S_ISSUE;
                    end else if (if_gnt_o) begin
                        owner_q     <= OWN_IFU;
                        mem_req_o   <= 1'b1;
                        mem_addr_o  <= {if_addr_i[ADDR_W-1:2], 2'b00};
                        mem_wren_o  <= 1'b0;
                        mem_wdata_o <= '0;
                        mem_bmask_o <= BMASK_ALL;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (resp_done) begin
                        if (owner_q == OWN_LSU) begin
                            lsu_rvalid_o <= 1'b1;
                            lsu_rdata_o  <= resp_data;
                            lsu_err_o    <= resp_err;
                        end else begin
                            if_rvalid_o  <= 1'b1;
                            if_rdata_o   <= resp_data;
                            if_err_o     <= resp_err;
                        end
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if_rvalid_o  <= 1'b0;
                    if_rdata_o   <= '0;
                    if_err_o     <= 1'b0;
                    lsu_rvalid_o <= 1'b0;
                    lsu_rdata_o  <= '0;
                    lsu_err_o    <= 1'b0;
                    mem_addr_o   <= '0;
                    mem_wren_o   <= 1'b0;
                    mem_wdata_o  <= '0;
                    mem_bmask_o  <= '0;
`ifdef MEM_ARB_RR_EN
                    last_owner_q <= owner_q;
`endif
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
